// File: rtl/ets_phase_stepper_pkg.sv
// Shared ETS clock-generator definitions: stepper states, position defaults, calibration limits.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ets_phase_stepper_pkg;

    localparam int ETS_POS_WIDTH = 8;

    // Highest fine-phase position reachable above the clock generator's calibration offset.
    localparam int ETS_MAX_POS = 255;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_STEP,
        ST_WAIT_DONE,
        ST_SETTLE
    } ets_state_e;

    function automatic int ets_cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ets_step_timer.sv
// Loadable down-counter shared by the PSDONE timeout and the post-step settle wait.
// Latency: load takes effect next cycle; expired decodes the registered count.
// Backpressure: none; dec is ignored once the count reaches zero.
module ets_step_timer #(
    parameter int CNT_W = 7
) (
    input  logic             ref_clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             expired
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge ref_clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/ets_phase_stepper.sv
// Walks the ETS DCM fine phase to an absolute target one PSEN step at a time.
// Latency: accept -> CHECK next cycle -> PSEN the cycle after; per step PSDONE latency + settle + 1.
// Backpressure: target_ready only in IDLE with the DCM locked; new targets wait out a move.
module ets_phase_stepper
    import ets_phase_stepper_pkg::*;
#(
    parameter int POS_WIDTH     = ETS_POS_WIDTH,
    parameter int MAX_POS       = ETS_MAX_POS,
    parameter int DONE_TIMEOUT  = 64,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 ref_clk,
    input  logic                 reset_n,
    input  logic [POS_WIDTH-1:0] target,
    input  logic                 target_valid,
    output logic                 target_ready,
    input  logic                 dcm_locked,
    input  logic                 ps_done,
    input  logic                 ps_overflow,
    output logic                 ps_en,
    output logic                 ps_incdec,
    output logic [POS_WIDTH-1:0] position,
    output logic                 busy,
    output logic                 settled,
    output logic                 error
);

    localparam int CNT_MAX = (DONE_TIMEOUT > SETTLE_CYCLES) ? DONE_TIMEOUT : SETTLE_CYCLES;
    localparam int CNT_W   = ets_cnt_width(CNT_MAX);

    localparam logic [POS_WIDTH-1:0] MAX_POS_V    = POS_WIDTH'(MAX_POS);
    // Counter counts down to zero inclusive, so N cycles of wait load N-1.
    localparam logic [CNT_W-1:0]     TIMEOUT_LOAD = CNT_W'((DONE_TIMEOUT > 0) ? DONE_TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0]     SETTLE_LOAD  = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    ets_state_e           state_q, state_d;
    logic [POS_WIDTH-1:0] position_q, position_d;
    logic [POS_WIDTH-1:0] goal_q, goal_d;
    logic                 dir_q, dir_d;
    logic                 ps_en_q, ps_en_d;
    logic                 ps_incdec_q, ps_incdec_d;
    logic                 settled_q, settled_d;
    logic                 error_q, error_d;

    logic                 tmr_load;
    logic [CNT_W-1:0]     tmr_load_val;
    logic                 tmr_dec;
    logic                 tmr_expired;

    ets_step_timer #(
        .CNT_W (CNT_W)
    ) u_step_timer (
        .ref_clk  (ref_clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .expired  (tmr_expired)
    );

    always_comb begin
        state_d      = state_q;
        position_d   = position_q;
        goal_d       = goal_q;
        dir_d        = dir_q;
        error_d      = error_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_dec      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (target_valid && dcm_locked) begin
                    goal_d  = (target > MAX_POS_V) ? MAX_POS_V : target;
                    error_d = 1'b0;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (position_q == goal_q) begin
                    state_d = ST_IDLE;
                end else begin
                    dir_d   = (goal_q > position_q);
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                tmr_load     = 1'b1;
                tmr_load_val = TIMEOUT_LOAD;
                state_d      = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (ps_done) begin
                    if (ps_overflow) begin
                        error_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        position_d   = dir_q ? (position_q + POS_WIDTH'(1))
                                             : (position_q - POS_WIDTH'(1));
                        tmr_load     = 1'b1;
                        tmr_load_val = SETTLE_LOAD;
                        state_d      = ST_SETTLE;
                    end
                end else if (tmr_expired) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (tmr_expired) begin
                    state_d = ST_CHECK;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Losing lock resets the DCM, which returns it to the calibration phase.
        if (!dcm_locked) begin
            state_d    = ST_IDLE;
            position_d = '0;
        end

        // Registered outputs decode the state being entered so they line up with that state.
        ps_en_d     = (state_d == ST_STEP);
        ps_incdec_d = ((state_d == ST_STEP) || (state_d == ST_WAIT_DONE)) && dir_d;
        settled_d   = (state_d == ST_CHECK) && (position_d == goal_d);
    end

    always_ff @(posedge ref_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            position_q  <= '0;
            goal_q      <= '0;
            dir_q       <= 1'b0;
            ps_en_q     <= 1'b0;
            ps_incdec_q <= 1'b0;
            settled_q   <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            position_q  <= position_d;
            goal_q      <= goal_d;
            dir_q       <= dir_d;
            ps_en_q     <= ps_en_d;
            ps_incdec_q <= ps_incdec_d;
            settled_q   <= settled_d;
            error_q     <= error_d;
        end
    end

    assign target_ready = (state_q == ST_IDLE) && dcm_locked;
    assign busy         = (state_q != ST_IDLE);
    assign ps_en        = ps_en_q;
    assign ps_incdec    = ps_incdec_q;
    assign position     = position_q;
    assign settled      = settled_q;
    assign error        = error_q;

endmodule

// File: tb/tb_ets_phase_stepper.sv
// Directed bench for ets_phase_stepper with a behavioural DCM answering PSEN with PSDONE.
`timescale 1ns/1ps
module tb_ets_phase_stepper;

    localparam int PW = 9;

    logic          ref_clk = 1'b0;
    logic          reset_n;
    logic [PW-1:0] target;
    logic          target_valid;
    logic          target_ready;
    logic          dcm_locked;
    logic          ps_done;
    logic          ps_overflow;
    logic          ps_en;
    logic          ps_incdec;
    logic [PW-1:0] position;
    logic          busy;
    logic          settled;
    logic          error;

    ets_phase_stepper #(
        .POS_WIDTH     (PW),
        .MAX_POS       (255),
        .DONE_TIMEOUT  (64),
        .SETTLE_CYCLES (4)
    ) dut (
        .ref_clk      (ref_clk),
        .reset_n      (reset_n),
        .target       (target),
        .target_valid (target_valid),
        .target_ready (target_ready),
        .dcm_locked   (dcm_locked),
        .ps_done      (ps_done),
        .ps_overflow  (ps_overflow),
        .ps_en        (ps_en),
        .ps_incdec    (ps_incdec),
        .position     (position),
        .busy         (busy),
        .settled      (settled),
        .error        (error)
    );

    always #5 ref_clk = ~ref_clk;

    int passed = 0;
    int total  = 0;

    int en_cnt = 0, inc_cnt = 0, dec_cnt = 0, settled_cnt = 0;
    logic [PW-1:0] pos_log[$];
    logic [PW-1:0] last_pos = '0;

    bit dcm_on   = 1'b1;
    int done_lat = 10;
    int ovf_at   = -1;
    int resp_idx = 0;

    always @(negedge ref_clk) begin
        if (ps_en === 1'b1) begin
            en_cnt <= en_cnt + 1;
            if (ps_incdec === 1'b1) inc_cnt <= inc_cnt + 1;
            else                    dec_cnt <= dec_cnt + 1;
        end
        if (settled === 1'b1) settled_cnt <= settled_cnt + 1;
        if (position !== last_pos) begin
            pos_log.push_back(position);
            last_pos <= position;
        end
    end

    // DCM model: PSDONE done_lat cycles after each PSEN, optionally flagging overflow.
    initial begin
        ps_done     = 1'b0;
        ps_overflow = 1'b0;
        forever begin
            @(negedge ref_clk);
            if (ps_en === 1'b1 && dcm_on) begin
                repeat (done_lat) @(negedge ref_clk);
                resp_idx    = resp_idx + 1;
                ps_done     = 1'b1;
                ps_overflow = (resp_idx == ovf_at);
                @(negedge ref_clk);
                ps_done     = 1'b0;
                ps_overflow = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    endtask

    task automatic send(input logic [PW-1:0] t);
        bit ok = 1'b0;
        target       = t;
        target_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            ok = (target_ready === 1'b1);
            @(negedge ref_clk);
        end
        target_valid = 1'b0;
        chk("accept", 32'(ok), 1);
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge ref_clk);
            ok = (busy === 1'b0);
        end
        chk("idle_in_budget", 32'(ok), 1);
    endtask

    int e0, i0, d0, s0, p0;

    initial begin
        reset_n      = 1'b0;
        dcm_locked   = 1'b1;
        target       = '0;
        target_valid = 1'b0;
        repeat (3) @(negedge ref_clk);
        chk("rst_position",  32'(position), 0);
        chk("rst_ps_en",     32'(ps_en), 0);
        chk("rst_ps_incdec", 32'(ps_incdec), 0);
        chk("rst_busy",      32'(busy), 0);
        chk("rst_settled",   32'(settled), 0);
        chk("rst_error",     32'(error), 0);
        chk("rst_ready",     32'(target_ready), 1);
        reset_n = 1'b1;
        @(negedge ref_clk);

        // 0 -> 3, PSDONE 10 cycles after each PSEN
        e0 = en_cnt; i0 = inc_cnt; d0 = dec_cnt; s0 = settled_cnt; p0 = pos_log.size();
        send(3);
        chk("t1_busy_check",   32'(busy), 1);
        chk("t1_ready_low",    32'(target_ready), 0);
        @(negedge ref_clk);
        chk("t1_psen_first",   32'(ps_en), 1);
        chk("t1_incdec_step",  32'(ps_incdec), 1);
        @(negedge ref_clk);
        chk("t1_psen_onecyc",  32'(ps_en), 0);
        chk("t1_incdec_wait",  32'(ps_incdec), 1);
        repeat (9) @(negedge ref_clk);
        chk("t1_pos_at_done",  32'(position), 0);
        @(negedge ref_clk);
        chk("t1_pos_after",    32'(position), 1);
        chk("t1_incdec_settle", 32'(ps_incdec), 0);
        wait_idle(400);
        chk("t1_en_pulses",    32'(en_cnt - e0), 3);
        chk("t1_inc_pulses",   32'(inc_cnt - i0), 3);
        chk("t1_dec_pulses",   32'(dec_cnt - d0), 0);
        chk("t1_settled_once", 32'(settled_cnt - s0), 1);
        chk("t1_pos_changes",  32'(pos_log.size() - p0), 3);
        if (pos_log.size() >= p0 + 3) begin
            chk("t1_pos_seq0", 32'(pos_log[p0]), 1);
            chk("t1_pos_seq1", 32'(pos_log[p0 + 1]), 2);
            chk("t1_pos_seq2", 32'(pos_log[p0 + 2]), 3);
        end
        chk("t1_position",     32'(position), 3);
        chk("t1_error",        32'(error), 0);

        // 3 -> 1
        e0 = en_cnt; i0 = inc_cnt; d0 = dec_cnt; s0 = settled_cnt;
        send(1);
        wait_idle(400);
        chk("t2_en_pulses",    32'(en_cnt - e0), 2);
        chk("t2_dec_pulses",   32'(dec_cnt - d0), 2);
        chk("t2_inc_pulses",   32'(inc_cnt - i0), 0);
        chk("t2_settled_once", 32'(settled_cnt - s0), 1);
        chk("t2_position",     32'(position), 1);

        // target equal to position settles immediately
        e0 = en_cnt;
        send(1);
        chk("t3_settled_n1",   32'(settled), 1);
        chk("t3_busy_n1",      32'(busy), 1);
        @(negedge ref_clk);
        chk("t3_settled_end",  32'(settled), 0);
        chk("t3_busy_end",     32'(busy), 0);
        chk("t3_no_psen",      32'(en_cnt - e0), 0);

        // clamp: 300 -> 255
        done_lat = 1;
        e0 = en_cnt; i0 = inc_cnt; s0 = settled_cnt;
        send(300);
        wait_idle(3000);
        chk("t4_position",     32'(position), 255);
        chk("t4_en_pulses",    32'(en_cnt - e0), 254);
        chk("t4_inc_pulses",   32'(inc_cnt - i0), 254);
        chk("t4_settled_once", 32'(settled_cnt - s0), 1);
        repeat (20) @(negedge ref_clk);
        chk("t4_no_more_psen", 32'(en_cnt - e0), 254);
        send(256);
        chk("t4_clamp_settle", 32'(settled), 1);
        wait_idle(50);
        chk("t4_pos_held",     32'(position), 255);

        // PSDONE withheld: timeout
        done_lat = 10;
        dcm_on   = 1'b0;
        e0 = en_cnt;
        send(250);
        @(negedge ref_clk);
        chk("t5_psen",         32'(ps_en), 1);
        chk("t5_incdec_dec",   32'(ps_incdec), 0);
        repeat (64) @(negedge ref_clk);
        chk("t5_err_early",    32'(error), 0);
        chk("t5_busy_early",   32'(busy), 1);
        @(negedge ref_clk);
        chk("t5_err_timeout",  32'(error), 1);
        chk("t5_idle",         32'(busy), 0);
        chk("t5_position",     32'(position), 255);
        chk("t5_incdec_idle",  32'(ps_incdec), 0);
        repeat (5) @(negedge ref_clk);
        chk("t5_single_psen",  32'(en_cnt - e0), 1);
        chk("t5_err_sticky",   32'(error), 1);
        dcm_on = 1'b1;
        send(255);
        chk("t5_err_cleared",  32'(error), 0);
        chk("t5_settled",      32'(settled), 1);
        wait_idle(50);

        // lock lost during WAIT_DONE, late PSDONE ignored
        e0 = en_cnt; s0 = settled_cnt;
        send(200);
        @(negedge ref_clk);
        chk("t6_psen",         32'(ps_en), 1);
        repeat (3) @(negedge ref_clk);
        dcm_locked = 1'b0;
        @(negedge ref_clk);
        chk("t6_idle",         32'(busy), 0);
        chk("t6_pos_zero",     32'(position), 0);
        chk("t6_psen_low",     32'(ps_en), 0);
        chk("t6_incdec_low",   32'(ps_incdec), 0);
        chk("t6_ready_low",    32'(target_ready), 0);
        chk("t6_err_same",     32'(error), 0);
        target       = 9'd7;
        target_valid = 1'b1;
        repeat (10) @(negedge ref_clk);
        chk("t6_late_done_pos", 32'(position), 0);
        chk("t6_ignored_valid", 32'(busy), 0);
        chk("t6_no_new_psen",  32'(en_cnt - e0), 1);
        chk("t6_no_settled",   32'(settled_cnt - s0), 0);
        target_valid = 1'b0;
        dcm_locked   = 1'b1;
        @(negedge ref_clk);
        chk("t6_ready_back",   32'(target_ready), 1);
        chk("t6_pos_relock",   32'(position), 0);

        // overflow reported with the second PSDONE
        e0 = en_cnt; i0 = inc_cnt; s0 = settled_cnt;
        ovf_at = resp_idx + 2;
        send(5);
        wait_idle(200);
        chk("t7_position",     32'(position), 1);
        chk("t7_error",        32'(error), 1);
        chk("t7_no_settled",   32'(settled_cnt - s0), 0);
        chk("t7_en_pulses",    32'(en_cnt - e0), 2);
        chk("t7_inc_pulses",   32'(inc_cnt - i0), 2);
        repeat (10) @(negedge ref_clk);
        chk("t7_stays_idle",   32'(en_cnt - e0), 2);
        ovf_at = -1;
        send(1);
        chk("t7_err_cleared",  32'(error), 0);
        chk("t7_settled",      32'(settled), 1);
        wait_idle(50);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
